// File: rtl/mux_share_arbiter.sv
// Round-robin arbiter owning the select of a shared 2:1 data mux, streaming the
// granted requester to one valid/ready consumer with a per-grant beat limit.
module mux_share_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_HOLD   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [1:0]            i_req,
    input  logic [DATA_WIDTH-1:0] i_data_0,
    input  logic [DATA_WIDTH-1:0] i_data_1,
    input  logic                  i_ready,
    output logic [1:0]            o_grant,
    output logic                  o_sel,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid
);

    localparam int unsigned        CNT_W   = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             last;
    logic             last_nxt;
    logic [1:0]       grant_nxt;
    logic             sel_nxt;
    logic             xfer;

    // Shared data path: the mux only steers, the arbiter owns the select
    assign o_data  = o_sel ? i_data_1 : i_data_0;
    assign o_valid = (o_grant != 2'b00) & i_req[o_sel];
    assign xfer    = o_valid & i_ready;

    // State register, with grant and select registered alongside the FSM
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            last    <= 1'b1;
            o_grant <= 2'b00;
            o_sel   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            last    <= last_nxt;
            o_grant <= grant_nxt;
            o_sel   <= sel_nxt;
        end
    end

    // Next state: release on own request drop, preempt once the beat limit is hit
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        cnt_inc   = (xfer && (cnt != CNT_MAX)) ? cnt + CNT_W'(1) : cnt;
        cnt_nxt   = cnt_inc;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (i_req == 2'b11) begin
                    state_nxt = last ? GNT0 : GNT1;
                end else if (i_req[0]) begin
                    state_nxt = GNT0;
                end else if (i_req[1]) begin
                    state_nxt = GNT1;
                end
            end
            GNT0: begin
                if (!i_req[0]) begin
                    state_nxt = i_req[1] ? GNT1 : IDLE;
                end else if ((cnt_inc == CNT_MAX) && i_req[1]) begin
                    state_nxt = GNT1;
                end
            end
            GNT1: begin
                if (!i_req[1]) begin
                    state_nxt = i_req[0] ? GNT0 : IDLE;
                end else if ((cnt_inc == CNT_MAX) && i_req[0]) begin
                    state_nxt = GNT0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (state_nxt != state) begin
            cnt_nxt = '0;
            if (state_nxt == GNT0) begin
                last_nxt = 1'b0;
            end else if (state_nxt == GNT1) begin
                last_nxt = 1'b1;
            end
        end
    end

    // Registered outputs follow the next state; select parks while idle
    always_comb begin
        grant_nxt = 2'b00;
        sel_nxt   = o_sel;
        case (state_nxt)
            GNT0: begin
                grant_nxt = 2'b01;
                sel_nxt   = 1'b0;
            end
            GNT1: begin
                grant_nxt = 2'b10;
                sel_nxt   = 1'b1;
            end
            default: begin
                grant_nxt = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Vector-table bench for mux_share_arbiter: each row drives one cycle of inputs
// and queues the outputs expected in that same cycle.
module tb_mux_share_arbiter;

    localparam int unsigned DW = 8;

    logic          clk;
    logic          rst_n;
    logic [1:0]    req;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic          ready;
    logic [1:0]    grant;
    logic          sel;
    logic [DW-1:0] data;
    logic          valid;

    typedef struct packed {
        logic [1:0]    req;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic          rdy;
        logic [1:0]    g;
        logic          s;
        logic          v;
    } vec_t;

    typedef struct packed {
        logic [1:0]    g;
        logic          s;
        logic          v;
        logic [DW-1:0] d;
    } exp_t;

    vec_t          vecs[$];
    exp_t          sb[$];
    int            checks = 0;
    int            passes = 0;
    int            vnum   = 0;
    logic [DW-1:0] pat    = 8'h10;

    mux_share_arbiter #(.DATA_WIDTH(DW), .MAX_HOLD(4)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_req    (req),
        .i_data_0 (d0),
        .i_data_1 (d1),
        .i_ready  (ready),
        .o_grant  (grant),
        .o_sel    (sel),
        .o_data   (data),
        .o_valid  (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data advances only after a cycle with ready high, so stalled beats stay stable
    function automatic vec_t mk(input logic [1:0] r, input logic rdy,
                                input logic [1:0] g, input logic s, input logic v);
        vec_t t;
        t.req = r;
        t.d0  = pat;
        t.d1  = ~pat;
        t.rdy = rdy;
        t.g   = g;
        t.s   = s;
        t.v   = v;
        if (rdy) pat = pat + 8'h01;
        return t;
    endfunction

    task automatic add(input int n, input logic [1:0] r, input logic rdy,
                       input logic [1:0] g, input logic s, input logic v);
        for (int i = 0; i < n; i++) vecs.push_back(mk(r, rdy, g, s, v));
    endtask

    task automatic step(input vec_t t);
        exp_t e;
        @(posedge clk);
        #1;
        req   = t.req;
        d0    = t.d0;
        d1    = t.d1;
        ready = t.rdy;
        e.g = t.g;
        e.s = t.s;
        e.v = t.v;
        e.d = t.s ? t.d1 : t.d0;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if ({grant, sel, valid, data} === {e.g, e.s, e.v, e.d}) begin
            passes++;
        end else begin
            $display("FAIL vec%0d: got grant=%b sel=%b valid=%b data=%h, expected grant=%b sel=%b valid=%b data=%h",
                     vnum, grant, sel, valid, data, e.g, e.s, e.v, e.d);
        end
        vnum++;
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got %h, expected %h", name, got, want);
    endtask

    initial begin
        vec_t t;
        rst_n = 1'b0;
        req   = 2'b11;
        d0    = '0;
        d1    = '0;
        ready = 1'b1;
        #2;
        chk("reset_grant", 8'(grant), 8'h00);
        chk("reset_sel",   8'(sel),   8'h00);
        chk("reset_valid", 8'(valid), 8'h00);
        @(negedge clk);
        req   = 2'b00;
        rst_n = 1'b1;

        // Contention from reset, preemption every 4 beats, release handoff, idle select hold
        add(1, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0);
        add(1, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0);
        add(4, 2'b11, 1'b1, 2'b01, 1'b0, 1'b1);
        add(4, 2'b11, 1'b1, 2'b10, 1'b1, 1'b1);
        add(2, 2'b11, 1'b1, 2'b01, 1'b0, 1'b1);
        add(1, 2'b10, 1'b1, 2'b01, 1'b0, 1'b0);
        add(1, 2'b10, 1'b1, 2'b10, 1'b1, 1'b1);
        add(1, 2'b00, 1'b1, 2'b10, 1'b1, 1'b0);
        add(1, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0);
        add(1, 2'b01, 1'b1, 2'b00, 1'b1, 1'b0);
        add(1, 2'b00, 1'b1, 2'b01, 1'b0, 1'b0);
        add(1, 2'b11, 1'b1, 2'b00, 1'b0, 1'b0);
        add(1, 2'b00, 1'b1, 2'b10, 1'b1, 1'b0);
        add(1, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0);

        // Backpressure: two beats, five stalled cycles, two more beats, then handoff
        add(1, 2'b11, 1'b1, 2'b00, 1'b1, 1'b0);
        add(2, 2'b11, 1'b1, 2'b01, 1'b0, 1'b1);
        add(5, 2'b11, 1'b0, 2'b01, 1'b0, 1'b1);
        add(2, 2'b11, 1'b1, 2'b01, 1'b0, 1'b1);
        add(1, 2'b00, 1'b1, 2'b10, 1'b1, 1'b0);
        add(1, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0);

        // Saturation: limit reached alone, other side arrives three cycles later
        add(1, 2'b01, 1'b1, 2'b00, 1'b1, 1'b0);
        add(4, 2'b01, 1'b1, 2'b01, 1'b0, 1'b1);
        add(3, 2'b01, 1'b1, 2'b01, 1'b0, 1'b1);
        add(1, 2'b11, 1'b1, 2'b01, 1'b0, 1'b1);
        add(1, 2'b11, 1'b1, 2'b10, 1'b1, 1'b1);
        add(1, 2'b00, 1'b1, 2'b10, 1'b1, 1'b0);
        add(1, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0);

        // Single requester streams 20 beats with no preemption
        t = mk(2'b10, 1'b1, 2'b00, 1'b1, 1'b0);
        t.d1 = 8'hA5;
        vecs.push_back(t);
        for (int i = 0; i < 20; i++) begin
            t = mk(2'b10, 1'b1, 2'b10, 1'b1, 1'b1);
            t.d1 = 8'hA5;
            vecs.push_back(t);
        end

        foreach (vecs[i]) step(vecs[i]);

        // Reset mid-grant drops everything immediately
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_grant", 8'(grant), 8'h00);
        chk("midrst_sel",   8'(sel),   8'h00);
        chk("midrst_valid", 8'(valid), 8'h00);
        @(negedge clk);
        req   = 2'b00;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step(mk(2'b00, 1'b1, 2'b00, 1'b0, 1'b0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
